// File: rtl/spu_sm_max_ctrl_if.sv
// Handshake/bus bundle for the softmax row-max sequencer.
// Row request, score-buffer read, running-max control and result channels.
//   slave  : sequencer view (drives busy, reads, comp ctrl, result)
//   master : environment view (drives start, row, abort, max_comp, ready)
interface spu_sm_max_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 12
);
    logic              start;
    logic [ADDR_W-1:0] row_base;
    logic [LEN_W-1:0]  row_len;
    logic              abort;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              comp_en;
    logic              comp_rst;
    logic [3:0]        lane_mask;
    logic [7:0]        max_comp;
    logic              max_valid;
    logic [7:0]        max_data;
    logic              max_ready;

    modport slave (
        input  start, row_base, row_len, abort,
        input  max_comp, max_ready,
        output busy, rd_en, rd_addr, comp_en, comp_rst,
        output lane_mask, max_valid, max_data
    );

    modport master (
        output start, row_base, row_len, abort,
        output max_comp, max_ready,
        input  busy, rd_en, rd_addr, comp_en, comp_rst,
        input  lane_mask, max_valid, max_data
    );
endinterface

// File: rtl/spu_sm_max_ctrl.sv
// Softmax row-maximum sequencer: walks one int8 row (4 lanes/word),
// drives the running-max unit and hands the row max downstream.
// Ports: core_clk, rst (async, active-high), bus (slave modport):
//   start/row_base/row_len/abort in, busy out,
//   rd_en/rd_addr out, comp_en/comp_rst/lane_mask out, max_comp in,
//   max_valid/max_data out, max_ready in.
module spu_sm_max_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 12,
    parameter int RD_LAT = 1
) (
    input  logic             core_clk,
    input  logic             rst,
    spu_sm_max_ctrl_if.slave bus
);
    localparam int         BW        = LEN_W - 1;
    localparam logic [7:0] NEG_FLOOR = 8'h81;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        HOLD,
        CLR
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BW-1:0]     left_q, left_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        tail_q, new_tail;
    logic [7:0]        mdata_q, mdata_d;
    logic              mvalid_q, mvalid_d;
    logic              crst_q, crst_d;
    logic              busy_q;
    logic              rd_d, last_d;
    logic              capture, flush;
    logic [BW-1:0]     beats;

    // Alignment line: bit 0 is the live read strobe, the
    // last stage feeds the registered comp_en/lane_mask.
    logic [RD_LAT-1:0] sr_v, sr_last;
    logic              comp_en_q;
    logic [3:0]        mask_q;

    // ceil(row_len / 4)
    assign beats = BW'(bus.row_len[LEN_W-1:2])
                 + BW'(|bus.row_len[1:0]);

    always_comb begin
        unique case (bus.row_len[1:0])
            2'd1:    new_tail = 4'b0001;
            2'd2:    new_tail = 4'b0011;
            2'd3:    new_tail = 4'b0111;
            default: new_tail = 4'b1111;
        endcase
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        left_d   = left_q;
        cnt_d    = cnt_q;
        mdata_d  = mdata_q;
        mvalid_d = 1'b0;
        crst_d   = 1'b0;
        rd_d     = 1'b0;
        last_d   = 1'b0;
        capture  = 1'b0;
        flush    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.row_len != '0) begin
                        state_d = ISSUE;
                        capture = 1'b1;
                        rd_d    = 1'b1;
                        addr_d  = bus.row_base;
                        left_d  = beats - BW'(1);
                        last_d  = (beats == BW'(1));
                    end else begin
                        state_d  = HOLD;
                        mdata_d  = NEG_FLOOR;
                        mvalid_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (left_q == '0) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    rd_d   = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    left_d = left_q - BW'(1);
                    last_d = (left_q == BW'(1));
                end
            end
            DRAIN: begin
                // RD_LAT+1 cycles: last read returns, then the
                // final running-max update lands in max_comp.
                if (cnt_q == 3'(RD_LAT)) begin
                    state_d  = HOLD;
                    mdata_d  = bus.max_comp;
                    mvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            HOLD: begin
                if (bus.max_ready) begin
                    state_d = CLR;
                    crst_d  = 1'b1;
                end else begin
                    mvalid_d = 1'b1;
                end
            end
            CLR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // abort beats a same-cycle handshake in HOLD
        if (bus.abort &&
            (state_q == ISSUE || state_q == DRAIN ||
             state_q == HOLD)) begin
            state_d  = CLR;
            rd_d     = 1'b0;
            last_d   = 1'b0;
            mvalid_d = 1'b0;
            crst_d   = 1'b1;
            flush    = 1'b1;
        end
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            addr_q   <= '0;
            left_q   <= '0;
            cnt_q    <= '0;
            tail_q   <= 4'b1111;
            mdata_q  <= NEG_FLOOR;
            mvalid_q <= 1'b0;
            crst_q   <= 1'b0;
        end else begin
            busy_q   <= (state_d != IDLE);
            addr_q   <= addr_d;
            left_q   <= left_d;
            cnt_q    <= cnt_d;
            mdata_q  <= mdata_d;
            mvalid_q <= mvalid_d;
            crst_q   <= crst_d;
            if (capture) begin
                tail_q <= new_tail;
            end
        end
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            sr_v      <= '0;
            sr_last   <= '0;
            comp_en_q <= 1'b0;
            mask_q    <= 4'b0000;
        end else if (flush) begin
            sr_v      <= '0;
            sr_last   <= '0;
            comp_en_q <= 1'b0;
            mask_q    <= 4'b0000;
        end else begin
            sr_v[0]    <= rd_d;
            sr_last[0] <= last_d;
            for (int i = 1; i < RD_LAT; i++) begin
                sr_v[i]    <= sr_v[i-1];
                sr_last[i] <= sr_last[i-1];
            end
            comp_en_q <= sr_v[RD_LAT-1];
            if (!sr_v[RD_LAT-1]) begin
                mask_q <= 4'b0000;
            end else if (sr_last[RD_LAT-1]) begin
                mask_q <= tail_q;
            end else begin
                mask_q <= 4'b1111;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.rd_en     = sr_v[0];
    assign bus.rd_addr   = addr_q;
    assign bus.comp_en   = comp_en_q;
    assign bus.comp_rst  = crst_q;
    assign bus.lane_mask = mask_q;
    assign bus.max_valid = mvalid_q;
    assign bus.max_data  = mdata_q;
endmodule

// File: tb/tb_spu_sm_max_ctrl.sv
// Bench for spu_sm_max_ctrl: score buffer + running-max mock,
// cycle-timeline reference model, directed and random rows.
module tb_spu_sm_max_ctrl;
    localparam int AW  = 10;
    localparam int LW  = 12;
    localparam int LAT = 1;
    localparam int INF = 32'h7fffffff;

    logic core_clk = 1'b0;
    logic rst      = 1'b1;
    always #5 core_clk = ~core_clk;

    spu_sm_max_ctrl_if #(.ADDR_W(AW), .LEN_W(LW)) bus();

    spu_sm_max_ctrl #(
        .ADDR_W(AW),
        .LEN_W (LW),
        .RD_LAT(LAT)
    ) dut (
        .core_clk(core_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // ---------------- environment: buffer + running max
    logic [31:0]       mem [1024];
    logic [31:0]       pipe [LAT];
    logic signed [7:0] run_max;
    assign bus.max_comp = run_max;

    function automatic logic signed [7:0] lanes_max(
        input logic signed [7:0] m, input logic [31:0] w,
        input logic [3:0] k);
        logic signed [7:0] v;
        for (int i = 0; i < 4; i++) begin
            v = k[i] ? w[8*i +: 8] : 8'h81;
            if (v > m) m = v;
        end
        return m;
    endfunction

    always @(posedge core_clk or posedge rst) begin
        if (rst) begin
            run_max <= 8'sh81;
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= bus.rd_en ? mem[bus.rd_addr] : 32'h0;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            if (bus.comp_rst)
                run_max <= 8'sh81;
            else if (bus.comp_en)
                run_max <= lanes_max(run_max, pipe[LAT-1],
                                     bus.lane_mask);
        end
    end

    // ---------------- reference model (timeline of one row)
    bit         m_act = 1'b0;
    int         m_T, m_end, m_hold, m_B, m_L;
    logic [9:0] m_base;
    logic [3:0] m_tail;
    logic [7:0] m_max;

    // max over the row's elements, element e at word e/4 lane e%4
    function automatic logic [7:0] row_max(input int base,
                                           input int len);
        logic signed [7:0] m, v;
        logic [31:0] w;
        m = -8'sd127;
        for (int e = 0; e < len; e++) begin
            w = mem[(base + e / 4) % 1024];
            v = w[8*(e%4) +: 8];
            if (v > m) m = v;
        end
        return m;
    endfunction

    always @(posedge core_clk) begin
        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act || cyc > m_end) begin
            if (bus.start) begin
                m_act  = 1'b1;
                m_T    = cyc + 1;
                m_L    = int'(bus.row_len);
                m_base = bus.row_base;
                m_B    = (m_L + 3) / 4;
                m_end  = INF;
                m_hold = (m_L == 0) ? m_T : m_T + m_B + LAT + 1;
                m_max  = row_max(int'(m_base), m_L);
                m_tail = (m_L % 4 == 0) ? 4'hF
                       : 4'((1 << (m_L % 4)) - 1);
            end
        end else if (cyc < m_end) begin
            if (bus.abort)
                m_end = cyc + 1;
            else if (cyc >= m_hold && bus.max_ready)
                m_end = cyc + 1;
        end
        cyc++;
    end

    always @(negedge core_clk) begin : cmp
        bit e_norm, e_clr, e_rd, e_cmp, e_mv;
        logic [9:0] e_addr;
        logic [3:0] e_mask;
        if (chk_on && !rst) begin
            e_norm = m_act && cyc < m_end;
            e_clr  = m_act && cyc == m_end;
            e_rd   = e_norm && cyc >= m_T && cyc < m_T + m_B;
            e_cmp  = e_norm && cyc >= m_T + LAT
                   && cyc < m_T + m_B + LAT;
            e_mv   = e_norm && cyc >= m_hold;
            e_addr = m_base + 10'(cyc - m_T);
            e_mask = (cyc == m_T + m_B - 1 + LAT) ? m_tail : 4'hF;
            chk("busy", bus.busy, e_norm | e_clr);
            chk("rd_en", bus.rd_en, e_rd);
            chk("comp_en", bus.comp_en, e_cmp);
            chk("comp_rst", bus.comp_rst, e_clr);
            chk("max_valid", bus.max_valid, e_mv);
            if (e_rd) chk("rd_addr", bus.rd_addr, e_addr);
            if (e_cmp) chk("lane_mask", bus.lane_mask, e_mask);
            if (e_mv) chk("max_data", bus.max_data, m_max);
        end
    end

    // ---------------- stimulus helpers
    function automatic logic [31:0] pack(input int a, input int b,
                                         input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic launch(input logic [9:0] b, input logic [11:0] l);
        @(negedge core_clk);
        bus.row_base = b;
        bus.row_len  = l;
        bus.start    = 1'b1;
        @(negedge core_clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(output int n, output int nrd,
                              output int ncmp, output logic [3:0] lm,
                              output logic [9:0] a0,
                              output logic [9:0] a1);
        n = 1; nrd = 0; ncmp = 0; lm = '0; a0 = '0; a1 = '0;
        while (!bus.max_valid && n < 60) begin
            if (bus.rd_en) begin
                if (nrd == 0) a0 = bus.rd_addr;
                if (nrd == 1) a1 = bus.rd_addr;
                nrd++;
            end
            if (bus.comp_en) begin
                ncmp++;
                lm = bus.lane_mask;
            end
            @(negedge core_clk);
            n++;
        end
        if (!bus.max_valid) chk("valid_timeout", bus.max_valid, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge core_clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", bus.busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_rd_en"}, bus.rd_en, 0);
        chk({tag, "_rd_addr"}, bus.rd_addr, 0);
        chk({tag, "_comp_en"}, bus.comp_en, 0);
        chk({tag, "_comp_rst"}, bus.comp_rst, 0);
        chk({tag, "_lane_mask"}, bus.lane_mask, 0);
        chk({tag, "_max_valid"}, bus.max_valid, 0);
        chk({tag, "_max_data"}, bus.max_data, 8'h81);
    endtask

    int         n, nrd, ncmp;
    logic [3:0] lm;
    logic [9:0] a0, a1;

    initial begin
        bus.start     = 1'b0;
        bus.row_base  = '0;
        bus.row_len   = '0;
        bus.abort     = 1'b0;
        bus.max_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst = 1'b1;
        repeat (3) @(negedge core_clk);
        chk_reset_vals("reset");
        rst    = 1'b0;
        chk_on = 1'b1;
        @(negedge core_clk);

        // basic two-beat row
        mem[10'h010] = pack(3, -5, 7, 1);
        mem[10'h011] = pack(-2, 9, 0, 4);
        launch(10'h010, 12'd8);
        wait_valid(n, nrd, ncmp, lm, a0, a1);
        chk("t1_valid_lat", n, 5);
        chk("t1_nrd", nrd, 2);
        chk("t1_ncmp", ncmp, 2);
        chk("t1_addr0", a0, 10'h010);
        chk("t1_addr1", a1, 10'h011);
        chk("t1_max", bus.max_data, 8'd9);
        @(negedge core_clk);
        chk("t1_comp_rst", bus.comp_rst, 1);
        @(negedge core_clk);
        chk("t1_rst_done", bus.comp_rst, 0);
        chk("t1_idle", bus.busy, 0);

        // partial last word
        mem[10'h020] = pack(3, -5, 7, 1);
        mem[10'h021] = pack(-1, -2, 100, 100);
        launch(10'h020, 12'd6);
        wait_valid(n, nrd, ncmp, lm, a0, a1);
        chk("t2_tail_mask", lm, 4'b0011);
        chk("t2_max", bus.max_data, 8'd7);
        wait_idle();

        // empty row
        launch(10'h100, 12'd0);
        wait_valid(n, nrd, ncmp, lm, a0, a1);
        chk("t3_valid_lat", n, 1);
        chk("t3_nrd", nrd, 0);
        chk("t3_ncmp", ncmp, 0);
        chk("t3_max", bus.max_data, 8'h81);
        wait_idle();

        // address wrap
        launch(10'h3FF, 12'd8);
        wait_valid(n, nrd, ncmp, lm, a0, a1);
        chk("t4_addr0", a0, 10'h3FF);
        chk("t4_addr1", a1, 10'h000);
        wait_idle();

        // hold with back-pressure, starts ignored
        mem[10'h040] = pack(-8, -9, -10, -11);
        mem[10'h041] = pack(-3, -20, -4, -100);
        mem[10'h042] = pack(-50, -6, -7, -1);
        bus.max_ready = 1'b0;
        launch(10'h040, 12'd12);
        wait_valid(n, nrd, ncmp, lm, a0, a1);
        for (int i = 0; i < 5; i++) begin
            bus.start    = 1'b1;
            bus.row_len  = 12'($urandom_range(0, 20));
            bus.row_base = 10'($urandom);
            @(negedge core_clk);
        end
        bus.start = 1'b0;
        chk("t5_held_valid", bus.max_valid, 1);
        chk("t5_held_max", bus.max_data, 8'hFF);
        bus.max_ready = 1'b1;
        wait_idle();

        // abort mid-issue
        launch(10'h080, 12'd32);
        repeat (2) @(negedge core_clk);
        bus.abort = 1'b1;
        @(negedge core_clk);
        bus.abort = 1'b0;
        chk("t6_comp_rst", bus.comp_rst, 1);
        chk("t6_rd_stop", bus.rd_en, 0);
        chk("t6_cmp_stop", bus.comp_en, 0);
        @(negedge core_clk);
        chk("t6_idle", bus.busy, 0);

        // async reset mid-row
        launch(10'h0C0, 12'd40);
        @(negedge core_clk);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        repeat (2) @(negedge core_clk);
        rst = 1'b0;
        @(negedge core_clk);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge core_clk);
            bus.start     = ($urandom % 5 == 0);
            bus.row_base  = 10'($urandom);
            bus.row_len   = ($urandom % 8 == 0) ? 12'd0
                          : 12'($urandom_range(1, 39));
            bus.abort     = ($urandom % 60 == 0);
            bus.max_ready = ($urandom % 3 != 0);
        end
        @(negedge core_clk);
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.max_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge core_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
